// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Assembles a byte stream into 33-bit words and holds the CPU until the image checks out.
module imem_loader #(
    parameter int INSTR_W         = 33,
    parameter int ADDR_W          = 9,
    parameter int BYTES_PER_INSTR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_data_i,
    output logic               byte_ready_o,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic               cpu_hold_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int IDX_W = $clog2(BYTES_PER_INSTR);
    localparam int ASM_W = 8 * BYTES_PER_INSTR;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_INSTR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_PAYLOAD,
        S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic               xfer;

    assign xfer = byte_valid_i & ready_q;

    // Next-state logic; every output is registered from the next state so
    // byte_ready_o never depends combinationally on byte_valid_i.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_HDR_LO;
                    acc_d   = '0;
                    addr_d  = '0;
                    idx_d   = '0;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    cnt_d[7:0] = byte_data_i;
                    acc_d      = acc_q ^ byte_data_i;
                    state_d    = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    acc_d = acc_q ^ byte_data_i;
                    if (|byte_data_i[7:1]) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d[8] = byte_data_i[0];
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    acc_d = acc_q ^ byte_data_i;
                    asm_d[{idx_q, 3'b000} +: 8] = byte_data_i;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        wdata_d = asm_d[INSTR_W-1:0];
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (addr_q == cnt_q) begin
                    state_d = S_CHECK;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_PAYLOAD;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (byte_data_i == acc_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                  (state_d == S_PAYLOAD) || (state_d == S_CHECK);
        we_d    = (state_d == S_WRITE);
        hold_d  = (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    // State and registered outputs; reset leaves the pipeline held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
